// File: rtl/iram_ctrl_if.sv
// iram_ctrl bus bundle: core miss request,
// word return, instruction RAM read port, status.
interface iram_ctrl_if #(
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = 16
);
  logic                 i_miss;
  logic [PC_SIZE-1:0]   ram_address;
  logic [WORD_SIZE-1:0] mem_word;
  logic                 word_ready;
  logic                 mem_req;
  logic [PC_SIZE-1:0]   mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_rvalid;
  logic                 busy;
  logic [CNT_W-1:0]     miss_count;

  modport slave (
    input  i_miss, ram_address,
    input  mem_rdata, mem_rvalid,
    output mem_word, word_ready,
    output mem_req, mem_addr,
    output busy, miss_count
  );

  modport master (
    output i_miss, ram_address,
    output mem_rdata, mem_rvalid,
    input  mem_word, word_ready,
    input  mem_req, mem_addr,
    input  busy, miss_count
  );
endinterface

// File: rtl/iram_ctrl.sv
// Instruction-RAM line refill controller:
// one outstanding word read, ascending order.
module iram_ctrl #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         nrst,
  iram_ctrl_if.slave  bus
);
  localparam int OFS  = $clog2(4 * LINE_WORDS);
  localparam int WC_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [WC_W-1:0]      wcnt;
  logic [PC_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0] word_q;
  logic                 rdy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last_w;
  logic                 start;
  logic                 got;
  logic [PC_SIZE-1:0]   line_base;

  assign last_w = (wcnt == WC_W'(LINE_WORDS - 1));
  assign start  = (state == IDLE) && bus.i_miss;
  assign got    = (state == WAIT) && bus.mem_rvalid;

  assign line_base = {
    bus.ram_address[PC_SIZE-1:OFS],
    {OFS{1'b0}}
  };

  // State register; reset aborts any refill
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // Next state: DONE waits for the miss to drop
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.i_miss) state_n = REQ;
      REQ:  state_n = WAIT;
      WAIT: begin
        if (bus.mem_rvalid)
          state_n = last_w ? DONE : REQ;
      end
      DONE: if (!bus.i_miss) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address/word counter, return word, miss count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcnt   <= '0;
      addr_q <= '0;
      word_q <= '0;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        addr_q <= line_base;
        wcnt   <= '0;
        if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (got) begin
        word_q <= bus.mem_rdata;
        rdy_q  <= 1'b1;
        if (!last_w) begin
          wcnt   <= wcnt + WC_W'(1);
          addr_q <= addr_q + PC_SIZE'(4);
        end
      end
    end
  end

  assign bus.mem_req    = (state == REQ);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_word   = word_q;
  assign bus.word_ready = rdy_q;
  assign bus.busy       = (state != IDLE);
  assign bus.miss_count = cnt_q;
endmodule

// File: doc/iram_ctrl.md
# iram_ctrl

Instruction-RAM refill controller sitting between the core's fetch unit and the external instruction RAM. On a cache miss signalled by the core (`i_miss` with `ram_address`), it fetches one full cache line word by word from the instruction RAM. Each word is returned to the core on `mem_word`, qualified by a one-cycle `word_ready` pulse. It also keeps a saturating miss counter for performance monitoring.

## Interface
Parameters:
- `PC_SIZE`, 32, width of byte addresses (matches the core's `pc_size`)
- `WORD_SIZE`, 32, width of a memory word (matches the core's `memory_word`)
- `LINE_WORDS`, 4, words per cache line; power of two, ≥2
- `CNT_W`, 16, width of the miss counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `nrst`  in  1  reset; one clock, asynchronous, active-low
- `i_miss`  in  1  miss request from the core; level, held until the line is delivered
- `ram_address`  in  PC_SIZE  byte address of the missing instruction
- `mem_word`  out  WORD_SIZE  word returned to the core
- `word_ready`  out  1  one-cycle pulse; `mem_word` is valid in this cycle
- `mem_req`  out  1  read request to the instruction RAM
- `mem_addr`  out  PC_SIZE  word-aligned byte address of the request
- `mem_rdata`  in  WORD_SIZE  read data from the instruction RAM
- `mem_rvalid`  in  1  `mem_rdata` is valid this cycle
- `busy`  out  1  controller is not in IDLE
- `miss_count`  out  CNT_W  number of line refills started; saturates

## Operation
- Line size is LINE_BYTES = 4·LINE_WORDS, with OFS = log2(LINE_BYTES).
- Line base address: `{ram_address[PC_SIZE-1:OFS], OFS'b0}`.
- Words are fetched in ascending order from the line base. There is no critical-word-first.
- There is exactly one outstanding request at a time.
- The state machine has four states: IDLE, REQ, WAIT, DONE.
  - **IDLE**: when `i_miss`=1, latch the base, clear the word counter `wcnt`, increment `miss_count` (unless saturated at all-ones), and go to REQ.
  - **REQ**: drive `mem_req`=1 and `mem_addr` = base + 4·`wcnt`. Go to WAIT next cycle.
  - **WAIT**: hold `mem_req`=0 until `mem_rvalid`=1. On that edge:
    - register `mem_word`←`mem_rdata` and set `word_ready`=1 for the next cycle;
    - if `wcnt`==LINE_WORDS-1, go to DONE; otherwise increment `wcnt` and go to REQ.
  - **DONE**: wait until `i_miss`=0, then go to IDLE. This prevents a stale miss from retriggering a refill.
- `mem_req` and `mem_addr` are Moore outputs decoded from the state register. `mem_addr` holds its last value outside REQ.
- `word_ready` and `mem_word` are registered. `mem_word` holds its value between pulses.
- `busy` = (state ≠ IDLE).

Boundary conditions:
- `i_miss` deasserting during REQ or WAIT is ignored; the line always completes.
- `mem_rvalid` outside WAIT is ignored.
- `ram_address` is sampled only in IDLE; later changes have no effect.
- `wcnt` wraps only via reset or a new refill, never mid-line.
- The final word and the DONE transition occur on the same edge.
- `miss_count` stays at 2^CNT_W-1 once reached.

## Timing
- Reset values:
  - state = IDLE;
  - `word_ready`, `mem_req`, `busy` = 0;
  - `mem_word`, `mem_addr`, `miss_count`, `wcnt` = 0.
- Reset asserted mid-refill aborts the refill immediately (asynchronously). A late `mem_rvalid` after reset release is ignored.
- Per-word cost is 2 + (RAM latency − 1) cycles. With a RAM that returns `mem_rvalid` in the cycle after `mem_req` (latency 1):
  - `i_miss` sampled at edge E0;
  - REQ in cycle 1; `mem_rvalid` in cycle 2;
  - `word_ready` in cycles 3, 5, 7, 9 for LINE_WORDS=4;
  - DONE from cycle 9; IDLE one cycle after `i_miss` is seen low.
- Minimum spacing between two refills: a fresh `i_miss` is accepted on the first IDLE cycle.

## Test plan
- **Reset**: assert `nrst`=0 mid-WAIT → all outputs return to their reset values within the same cycle. After release, a pulse on `mem_rvalid` produces no `word_ready`.
- **Basic refill**:
  - Stimulus: `ram_address`=0x0000_0104, LINE_WORDS=4, RAM latency 1, RAM returning data = address.
  - Required: `mem_addr` = 0x100, 0x104, 0x108, 0x10C in that order, and `mem_word` = the same values with `word_ready` in cycles 3, 5, 7, 9.
  - Required: `miss_count`=1.
- **Variable latency**: RAM delays `mem_rvalid` by 1, 4, 2 and 7 cycles → exactly one `word_ready` per word, `mem_req` is never asserted while WAIT is pending, and data order is preserved.
- **Miss held / dropped**:
  - Hold `i_miss` high 5 cycles past the last word → no new refill, `busy` stays 1, then IDLE after release.
  - Drop `i_miss` during WAIT of word 1 → all 4 words are still delivered.
- **Back-to-back refills**: line at 0x200, then a miss at 0x3FC → the second refill fetches 0x3F0..0x3FC, and `miss_count`=2.
- **Saturation**: CNT_W=2, 5 refills → `miss_count` sequence 1, 2, 3, 3, 3.
